// File: rtl/audio_fifo_pkg.sv
// Shared constants and the config-word decode for the audio sample FIFO.
package audio_fifo_pkg;

  // Bus addresses. The address decode happens one level up, so these are reference values only.
  localparam logic [31:0] AUDIO_DATA_ADDR = 32'h0000_0400;
  localparam logic [31:0] AUDIO_CFG_ADDR  = 32'h0000_0404;

  localparam int DIV_W = 16;

  // status_o bit positions
  localparam int STAT_FULL_BIT   = 0;
  localparam int STAT_UNF_BIT    = 1;
  localparam int STAT_OVF_BIT    = 2;
  localparam int STAT_IRQ_EN_BIT = 3;
  localparam int STAT_COUNT_LSB  = 16;
  localparam int STAT_COUNT_MSB  = 23;

  // Config word field positions
  localparam int DIV_LSB    = 0;
  localparam int DIV_MSB    = 15;
  localparam int IRQ_EN_BIT = 16;
  localparam int FLUSH_BIT  = 30;
  localparam int CLR_BIT    = 31;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             irq_en;
    logic             flush;
    logic             clr;
  } cfg_t;

  // Split a config store into fields. A divider of 0 would never tick, so it is mapped to 1.
  function automatic cfg_t decode_cfg(input logic [31:0] word);
    cfg_t c;
    c.div    = word[DIV_MSB:DIV_LSB];
    if (c.div == '0) c.div = DIV_W'(1);
    c.irq_en = word[IRQ_EN_BIT];
    c.flush  = word[FLUSH_BIT];
    c.clr    = word[CLR_BIT];
    return c;
  endfunction

endpackage

// File: rtl/sample_rate_tick.sv
// Programmable sample-rate divider: emits a one-cycle tick every div clocks.
module sample_rate_tick
  import audio_fifo_pkg::*;
#(
  parameter int unsigned DIV_RESET = 1134
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  // Next-state: a restart loads a new divider and restarts the count; otherwise count down and reload at zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    div_d = div_q;
    cnt_d = cnt_q;
    if (restart_i) begin
      div_d = div_i;
      cnt_d = div_i - DIV_W'(1);
    end else if (tick_o) begin
      cnt_d = div_q - DIV_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Divider and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DIV_RESET);
      cnt_q <= DIV_W'(DIV_RESET - 1);
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// CPU-filled sample FIFO drained at the audio sample rate, feeding audio_pwm.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned DIV_RESET = 1134,
  parameter int unsigned LOW_WM    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic                cfg_we_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         status_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  output logic                irq_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                irq_en_q, irq_en_d;
  logic                irq_q, irq_d;

  cfg_t cfg;
  logic tick, empty, full, flush, clr;
  logic do_push, do_pop, ovf_set, unf_set;

  assign cfg   = decode_cfg(wdata_i);
  assign flush = cfg_we_i && cfg.flush;
  assign clr   = cfg_we_i && cfg.clr;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  sample_rate_tick #(
    .DIV_RESET (DIV_RESET)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (cfg_we_i),
    .div_i     (cfg.div),
    .tick_o    (tick)
  );

  // Push/pop arbitration. A flush discards the buffer, so it suppresses the push, the pop and any underrun that cycle.
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    do_pop  = tick && !empty && !flush;
    unf_set = tick && empty && !flush;
    do_push = we_i && !flush && (!full || do_pop);
    ovf_set = we_i && !flush && full && !do_pop;
  end

  // Next-state for pointers, count, sample output, sticky flags and the watermark interrupt.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    sample_d = do_pop ? mem_q[rd_ptr_q] : sample_q;
    valid_d  = do_pop;
    // Clear beats a same-cycle set.
    ovf_d    = clr ? 1'b0 : (ovf_q || ovf_set);
    unf_d    = clr ? 1'b0 : (unf_q || unf_set);
    irq_en_d = cfg_we_i ? cfg.irq_en : irq_en_q;
    irq_d    = irq_en_d && (count_d <= CNT_W'(LOW_WM));
  end

  // Sample storage.
  // NOTE: the data array carries no reset; pointers and count define which entries are valid, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i[SAMPLE_W-1:0];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // Status word assembled from registered state.
  always_comb begin
    status_o = '0;
    status_o[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(count_q);
    status_o[STAT_IRQ_EN_BIT] = irq_en_q;
    status_o[STAT_OVF_BIT]    = ovf_q;
    status_o[STAT_UNF_BIT]    = unf_q;
    status_o[STAT_FULL_BIT]   = full;
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: playback pacing, overflow, full-on-tick, watermark IRQ, flush and reset.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] status_o;
  logic [7:0]  sample_o;
  logic        sample_valid_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail = 0;

  audio_sample_fifo #(
    .DEPTH     (16),
    .SAMPLE_W  (8),
    .DIV_RESET (1134),
    .LOW_WM    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .we_i           (we_i),
    .cfg_we_i       (cfg_we_i),
    .wdata_i        (wdata_i),
    .status_o       (status_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we_i = 1'b0; cfg_we_i = 1'b0; wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    wdata_i = {24'hA5A5A5, v}; we_i = 1'b1;
    step();
    we_i = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] w);
    wdata_i = w; cfg_we_i = 1'b1;
    step();
    cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sample_o !== 8'h80) begin n_fail++; $display("FAIL rst_sample: got %h exp 80", sample_o); end
    n_checks++; if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", sample_valid_o); end
    n_checks++; if (status_o !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h exp 00000000", status_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", irq_o); end
    // Default divider 1134: first (empty) tick lands on the 1134th edge after release.
    repeat (1133) step();
    n_checks++; if (status_o[1] !== 1'b0) begin n_fail++; $display("FAIL rst_div_early: unf got %b exp 0", status_o[1]); end
    step();
    n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL rst_div_tick: unf got %b exp 1", status_o[1]); end
  endtask

  task automatic test_playback();
    logic [7:0] exp_s [3];
    exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h33;
    do_reset();
    cfg(32'd4);
    push(8'h11); push(8'h22); push(8'h33);
    n_checks++; if (status_o[23:16] !== 8'd3) begin n_fail++; $display("FAIL pb_count3: got %0d exp 3", status_o[23:16]); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        repeat (3) begin
          step();
          n_checks++; if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL pb_gap%0d: valid got %b exp 0", i, sample_valid_o); end
        end
      end
      step();
      n_checks++; if (sample_valid_o !== 1'b1) begin n_fail++; $display("FAIL pb_valid%0d: got %b exp 1", i, sample_valid_o); end
      n_checks++; if (sample_o !== exp_s[i]) begin n_fail++; $display("FAIL pb_sample%0d: got %h exp %h", i, sample_o, exp_s[i]); end
    end
    n_checks++; if (status_o[23:16] !== 8'd0) begin n_fail++; $display("FAIL pb_count0: got %0d exp 0", status_o[23:16]); end
    repeat (3) step();
    n_checks++; if (status_o[1] !== 1'b0) begin n_fail++; $display("FAIL pb_unf_early: got %b exp 0", status_o[1]); end
    step();
    n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL pb_unf: got %b exp 1", status_o[1]); end
    n_checks++; if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL pb_unf_valid: got %b exp 0", sample_valid_o); end
    n_checks++; if (sample_o !== 8'h33) begin n_fail++; $display("FAIL pb_unf_hold: got %h exp 33", sample_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    cfg(32'd65535);
    for (int i = 0; i < 17; i++) push(8'hA0 + 8'(i));
    n_checks++; if (status_o[23:16] !== 8'd16) begin n_fail++; $display("FAIL ovf_count: got %0d exp 16", status_o[23:16]); end
    n_checks++; if (status_o[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b exp 1", status_o[0]); end
    n_checks++; if (status_o[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", status_o[2]); end
    cfg(32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'hA0 + 8'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d: valid %b sample %h exp valid 1 sample %h", i, sample_valid_o, sample_o, 8'hA0 + 8'(i));
      end
    end
    step();
    n_checks++; if (sample_valid_o !== 1'b0 || sample_o !== 8'hAF) begin
      n_fail++; $display("FAIL ovf_17th_absent: valid %b sample %h exp valid 0 sample af", sample_valid_o, sample_o);
    end
    n_checks++; if (status_o[23:16] !== 8'd0) begin n_fail++; $display("FAIL ovf_drained: count got %0d exp 0", status_o[23:16]); end
  endtask

  task automatic test_full_push_on_tick();
    do_reset();
    cfg(32'd65535);
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    // Divider 3: counter 2,1,0 -> the third cycle after the write is the tick cycle.
    cfg(32'd3);
    step(); step();
    push(8'h5A);
    n_checks++; if (status_o[23:16] !== 8'd16) begin n_fail++; $display("FAIL fpt_count: got %0d exp 16", status_o[23:16]); end
    n_checks++; if (status_o[2] !== 1'b0) begin n_fail++; $display("FAIL fpt_ovf: got %b exp 0", status_o[2]); end
    n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'h40) begin
      n_fail++; $display("FAIL fpt_pop: valid %b sample %h exp valid 1 sample 40", sample_valid_o, sample_o);
    end
    cfg(32'd1);
    repeat (16) step();
    n_checks++; if (sample_o !== 8'h5A) begin n_fail++; $display("FAIL fpt_tail: got %h exp 5a", sample_o); end
    n_checks++; if (status_o[23:16] !== 8'd0) begin n_fail++; $display("FAIL fpt_empty: count got %0d exp 0", status_o[23:16]); end
  endtask

  task automatic test_irq_watermark();
    do_reset();
    cfg(32'h0001_FFFF);
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_six: got %b exp 0", irq_o); end
    cfg(32'h0001_0002);
    step();
    step();
    n_checks++; if (status_o[23:16] !== 8'd5 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_five: count %0d irq %b exp count 5 irq 0", status_o[23:16], irq_o);
    end
    step();
    step();
    n_checks++; if (status_o[23:16] !== 8'd4 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_four: count %0d irq %b exp count 4 irq 1", status_o[23:16], irq_o);
    end
    push(8'h99);
    n_checks++; if (status_o[23:16] !== 8'd5 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_refill: count %0d irq %b exp count 5 irq 0", status_o[23:16], irq_o);
    end
  endtask

  task automatic test_flush_clear();
    do_reset();
    cfg(32'd65535);
    push(8'h77);
    cfg(32'd1);
    step();
    cfg(32'd65535);
    n_checks++; if (status_o[1] !== 1'b1 || sample_o !== 8'h77) begin
      n_fail++; $display("FAIL fl_setup_unf: unf %b sample %h exp unf 1 sample 77", status_o[1], sample_o);
    end
    for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
    cfg(32'h4000_FFFF);
    n_checks++; if (status_o[23:16] !== 8'd0 || status_o[2] !== 1'b1) begin
      n_fail++; $display("FAIL fl_flush_keeps_ovf: count %0d ovf %b exp count 0 ovf 1", status_o[23:16], status_o[2]);
    end
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    n_checks++; if (status_o[23:16] !== 8'd8) begin n_fail++; $display("FAIL fl_eight: count got %0d exp 8", status_o[23:16]); end
    // Flush + clear + div=10 together with a push: the flush must win over the push.
    wdata_i = 32'hC000_000A; cfg_we_i = 1'b1; we_i = 1'b1;
    step();
    cfg_we_i = 1'b0; we_i = 1'b0;
    n_checks++; if (status_o !== 32'h0) begin n_fail++; $display("FAIL fl_status: got %h exp 00000000", status_o); end
    n_checks++; if (sample_o !== 8'h77 || sample_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL fl_sample_hold: sample %h valid %b exp sample 77 valid 0", sample_o, sample_valid_o);
    end
    repeat (9) step();
    n_checks++; if (status_o[1] !== 1'b0) begin n_fail++; $display("FAIL fl_tick_early: unf got %b exp 0", status_o[1]); end
    step();
    n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL fl_tick10: unf got %b exp 1", status_o[1]); end
    // Config and push together without flush: the push still lands.
    wdata_i = 32'h0000_0005; cfg_we_i = 1'b1; we_i = 1'b1;
    step();
    cfg_we_i = 1'b0; we_i = 1'b0;
    n_checks++; if (status_o[23:16] !== 8'd1) begin n_fail++; $display("FAIL fl_cfg_push: count got %0d exp 1", status_o[23:16]); end
    // Divider 0 behaves as 1: the next cycle ticks and pops.
    cfg(32'd0);
    step();
    n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'h05) begin
      n_fail++; $display("FAIL fl_div0: valid %b sample %h exp valid 1 sample 05", sample_valid_o, sample_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg(32'd65535);
    push(8'h10); push(8'h20); push(8'h30);
    cfg(32'h0001_0001);
    step();
    n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'h10) begin
      n_fail++; $display("FAIL ar_predrain: valid %b sample %h exp valid 1 sample 10", sample_valid_o, sample_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sample_o !== 8'h80 || sample_valid_o !== 1'b0 || status_o !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_async: sample %h valid %b status %h irq %b exp 80 0 00000000 0", sample_o, sample_valid_o, status_o, irq_o);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (sample_valid_o !== 1'b0 || status_o[23:16] !== 8'd0) begin
        n_fail++; $display("FAIL ar_quiet%0d: valid %b count %0d exp valid 0 count 0", i, sample_valid_o, status_o[23:16]);
      end
    end
    push(8'h44);
    cfg(32'd1);
    step();
    n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'h44) begin
      n_fail++; $display("FAIL ar_resume: valid %b sample %h exp valid 1 sample 44", sample_valid_o, sample_o);
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_overflow();
    test_full_push_on_tick();
    test_irq_watermark();
    test_flush_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
